// File: rtl/pong_engine.sv
// -----------------------------------------------------------------------------
// pong_engine
//
// Purpose:
//   Tick-driven game-state engine for the VGA pong display. It holds the ball,
//   the two paddles, both scores and a SERVE/PLAY/POINT/OVER state machine.
//   State advances only on cycles where `tick` is high, normally once per
//   frame. The exception is `start`, which restarts a finished game at once.
//
// Optional build macro:
//   TWO_PLAYER_EN - adds up2/down2 inputs that steer the right paddle by hand
//                   with the same rules as the left paddle. When it is not
//                   defined, the right paddle is driven by the CPU tracker.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   tick         in   one-cycle update strobe
//   up / down    in   player paddle controls (level)
//   up2 / down2  in   right paddle controls (TWO_PLAYER_EN builds only)
//   pause        in   freezes ball, paddles and serve counter while high
//   start        in   one-cycle pulse; restarts the game from OVER
//   ball_x/_y    out  ball top-left corner
//   player_y     out  left paddle top
//   cpu_y        out  right paddle top
//   player_score out  left score
//   cpu_score    out  right score
//   game_state   out  0=SERVE 1=PLAY 2=POINT 3=OVER
//   point        out  one-cycle pulse when a point is scored
//   game_over    out  high while in OVER
// -----------------------------------------------------------------------------
module pong_engine #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BORDER      = 20,
  parameter int BALL_SIZE   = 10,
  parameter int PAD_W       = 20,
  parameter int PAD_H       = 120,
  parameter int PAD_SPEED   = 8,
  parameter int BALL_SPEED  = 4,
  parameter int WIN_SCORE   = 8,
  parameter int SCORE_W     = 4,
  parameter int SERVE_TICKS = 60,
  parameter int DEADBAND    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               up,
  input  logic               down,
`ifdef TWO_PLAYER_EN
  input  logic               up2,
  input  logic               down2,
`endif
  input  logic               pause,
  input  logic               start,
  output logic [10:0]        ball_x,
  output logic [10:0]        ball_y,
  output logic [10:0]        player_y,
  output logic [10:0]        cpu_y,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] cpu_score,
  output logic [1:0]         game_state,
  output logic               point,
  output logic               game_over
);

  typedef logic signed [11:0] pos_t;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam int CNT_W = (SERVE_TICKS < 2) ? 1 : $clog2(SERVE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SERVE_TICKS);

  localparam pos_t BX0     = pos_t'((H_RES - BALL_SIZE) / 2);
  localparam pos_t BY0     = pos_t'((V_RES - BALL_SIZE) / 2);
  localparam pos_t PY0     = pos_t'((V_RES - PAD_H) / 2);
  localparam pos_t PMIN    = pos_t'(BORDER);
  localparam pos_t PMAX    = pos_t'(V_RES - BORDER - PAD_H);
  localparam pos_t BX_MIN  = pos_t'(BORDER);
  localparam pos_t BX_MAX  = pos_t'(H_RES - BORDER - BALL_SIZE);
  localparam pos_t BY_MIN  = pos_t'(BORDER);
  localparam pos_t BY_MAX  = pos_t'(V_RES - BORDER - BALL_SIZE);
  localparam pos_t PXL_R   = pos_t'(2 * BORDER + PAD_W);           // player paddle face
  localparam pos_t PXR     = pos_t'(H_RES - 2 * BORDER - PAD_W);   // CPU paddle face
  localparam pos_t R_EDGE  = pos_t'(H_RES - BORDER);
  localparam pos_t BALL    = pos_t'(BALL_SIZE);
  localparam pos_t PADH    = pos_t'(PAD_H);
  localparam pos_t S_PAD   = pos_t'(PAD_SPEED);
  localparam pos_t S_BALL  = pos_t'(BALL_SPEED);
  localparam pos_t HALF_B  = pos_t'(BALL_SIZE / 2);
  localparam pos_t HALF_P  = pos_t'(PAD_H / 2);
`ifndef TWO_PLAYER_EN
  localparam pos_t DBAND   = pos_t'(DEADBAND);
`endif
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  function automatic pos_t clamp(input pos_t v, input pos_t lo, input pos_t hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  // Manual paddle step: exactly one of the two buttons moves the paddle.
  function automatic pos_t pad_step(input logic go_up, input logic go_down);
    if (go_up && !go_down)      return -S_PAD;
    else if (go_down && !go_up) return S_PAD;
    else                        return '0;
  endfunction

  // Registered state. Velocities only ever take +/-BALL_SPEED, so a sign bit
  // per axis is all that needs storing.
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [10:0]        ball_x_q, ball_x_d;
  logic [10:0]        ball_y_q, ball_y_d;
  logic [10:0]        player_y_q, player_y_d;
  logic [10:0]        cpu_y_q, cpu_y_d;
  logic               vx_neg_q, vx_neg_d;
  logic               vy_neg_q, vy_neg_d;
  logic [SCORE_W-1:0] player_score_q, player_score_d;
  logic [SCORE_W-1:0] cpu_score_q, cpu_score_d;
  logic               point_q, point_d;

  // Signed views of the current positions for the motion maths.
  pos_t bx, by, py, cy, vx, vy;
  assign bx = pos_t'({1'b0, ball_x_q});
  assign by = pos_t'({1'b0, ball_y_q});
  assign py = pos_t'({1'b0, player_y_q});
  assign cy = pos_t'({1'b0, cpu_y_q});
  assign vx = vx_neg_q ? -S_BALL : S_BALL;
  assign vy = vy_neg_q ? -S_BALL : S_BALL;

  // ---------------------------------------------------------------------------
  // Paddle candidate positions (applied only when the FSM allows motion)
  // ---------------------------------------------------------------------------
  pos_t p_next, c_next;

  assign p_next = clamp(py + pad_step(up, down), PMIN, PMAX);

`ifdef TWO_PLAYER_EN
  assign c_next = clamp(cy + pad_step(up2, down2), PMIN, PMAX);
`else
  pos_t err;
  assign err = (by + HALF_B) - (cy + HALF_P);

  always_comb begin
    c_next = cy;
    if (!vx_neg_q) begin
      // Ball approaching: chase its centre, ignoring small offsets.
      if (err > DBAND)       c_next = clamp(cy + S_PAD, PMIN, PMAX);
      else if (err < -DBAND) c_next = clamp(cy - S_PAD, PMIN, PMAX);
    end else begin
      // Ball receding: drift back to the centre without overshooting it.
      if (cy > PY0)      c_next = (cy - PY0 > S_PAD) ? cy - S_PAD : PY0;
      else if (cy < PY0) c_next = (PY0 - cy > S_PAD) ? cy + S_PAD : PY0;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Ball motion for one PLAY tick
  // ---------------------------------------------------------------------------
  pos_t nx, ny, nx_fin;
  logic vx_neg_n, vy_neg_n;
  logic hit_p, hit_c, score_c, score_p;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    nx       = bx + vx;
    ny       = by + vy;
    vx_neg_n = vx_neg_q;
    vy_neg_n = vy_neg_q;

    // Walls first; the paddle overlap test then sees the corrected height.
    if (ny < BY_MIN) begin
      ny       = BY_MIN;
      vy_neg_n = 1'b0;
    end else if (ny > BY_MAX) begin
      ny       = BY_MAX;
      vy_neg_n = 1'b1;
    end

    // A hit needs the ball to cross the paddle face during this tick.
    hit_p = vx_neg_q && (bx >= PXL_R) && (nx < PXL_R) &&
            (ny + BALL > py) && (ny < py + PADH);
    hit_c = !vx_neg_q && (bx + BALL <= PXR) && (nx + BALL > PXR) &&
            (ny + BALL > cy) && (ny < cy + PADH);

    score_c = !hit_p && !hit_c && (nx < BX_MIN);
    score_p = !hit_p && !hit_c && !score_c && (nx + BALL > R_EDGE);

    nx_fin = nx;
    if (hit_p) begin
      nx_fin   = PXL_R;
      vx_neg_n = 1'b0;
    end else if (hit_c) begin
      nx_fin   = PXR - BALL;
      vx_neg_n = 1'b1;
    end else if (score_c || score_p) begin
      nx_fin   = clamp(nx, BX_MIN, BX_MAX);
    end
  end

  // ---------------------------------------------------------------------------
  // Game FSM: next-state and register updates
  // ---------------------------------------------------------------------------
  logic               move_en;
  logic [SCORE_W-1:0] cpu_inc, player_inc;

  assign move_en    = tick && !pause;
  assign cpu_inc    = cpu_score_q + 1'b1;
  assign player_inc = player_score_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ball_x_d       = ball_x_q;
    ball_y_d       = ball_y_q;
    player_y_d     = player_y_q;
    cpu_y_d        = cpu_y_q;
    vx_neg_d       = vx_neg_q;
    vy_neg_d       = vy_neg_q;
    player_score_d = player_score_q;
    cpu_score_d    = cpu_score_q;
    point_d        = 1'b0;

    case (state_q)
      ST_SERVE: begin
        if (move_en) begin
          player_y_d = p_next[10:0];
          cpu_y_d    = c_next[10:0];
          ball_x_d   = BX0[10:0];
          ball_y_d   = BY0[10:0];
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      ST_PLAY: begin
        if (move_en) begin
          player_y_d = p_next[10:0];
          cpu_y_d    = c_next[10:0];
          ball_x_d   = nx_fin[10:0];
          ball_y_d   = ny[10:0];
          vx_neg_d   = vx_neg_n;
          vy_neg_d   = vy_neg_n;
          if (score_c) begin
            cpu_score_d = cpu_inc;
            point_d     = 1'b1;
            vx_neg_d    = 1'b1;   // serve toward the player who conceded
            state_d     = (cpu_inc == WIN) ? ST_OVER : ST_POINT;
          end else if (score_p) begin
            player_score_d = player_inc;
            point_d        = 1'b1;
            vx_neg_d       = 1'b0;
            state_d        = (player_inc == WIN) ? ST_OVER : ST_POINT;
          end
        end
      end

      ST_POINT: begin
        if (tick) begin
          ball_x_d = BX0[10:0];
          ball_y_d = BY0[10:0];
          cnt_d    = CNT_INIT;
          state_d  = ST_SERVE;
        end
      end

      ST_OVER: begin
        // start does not wait for tick and is not masked by pause.
        if (start) begin
          player_score_d = '0;
          cpu_score_d    = '0;
          player_y_d     = PY0[10:0];
          cpu_y_d        = PY0[10:0];
          ball_x_d       = BX0[10:0];
          ball_y_d       = BY0[10:0];
          vx_neg_d       = 1'b1;
          vy_neg_d       = 1'b0;
          cnt_d          = CNT_INIT;
          state_d        = ST_SERVE;
        end
      end

      default: state_d = ST_SERVE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_SERVE;
      cnt_q          <= CNT_INIT;
      ball_x_q       <= BX0[10:0];
      ball_y_q       <= BY0[10:0];
      player_y_q     <= PY0[10:0];
      cpu_y_q        <= PY0[10:0];
      vx_neg_q       <= 1'b1;
      vy_neg_q       <= 1'b0;
      player_score_q <= '0;
      cpu_score_q    <= '0;
      point_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ball_x_q       <= ball_x_d;
      ball_y_q       <= ball_y_d;
      player_y_q     <= player_y_d;
      cpu_y_q        <= cpu_y_d;
      vx_neg_q       <= vx_neg_d;
      vy_neg_q       <= vy_neg_d;
      player_score_q <= player_score_d;
      cpu_score_q    <= cpu_score_d;
      point_q        <= point_d;
    end
  end

  assign ball_x       = ball_x_q;
  assign ball_y       = ball_y_q;
  assign player_y     = player_y_q;
  assign cpu_y        = cpu_y_q;
  assign player_score = player_score_q;
  assign cpu_score    = cpu_score_q;
  assign game_state   = state_q;
  assign point        = point_q;
  assign game_over    = (state_q == ST_OVER);

endmodule

// File: tb/tb_pong_engine.sv
// -----------------------------------------------------------------------------
// tb_pong_engine
//
// Directed bench for pong_engine with default parameters. Ball trajectories
// are deterministic, so expected positions below are hand-derived from the
// serve point (315,235) moving (-4,+4) per PLAY tick ("k" = PLAY tick count).
// With the left paddle parked at 180 the CPU wins every rally, and rallies
// alternate between a bottom bounce (k=54, y=450) and a top bounce (k=54,
// y=20); the CPU scores at k=74 when x would drop to 19.
// -----------------------------------------------------------------------------
module tb_pong_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        up = 1'b0;
  logic        down = 1'b0;
  logic        pause = 1'b0;
  logic        start = 1'b0;
  logic [10:0] ball_x, ball_y, player_y, cpu_y;
  logic [3:0]  player_score, cpu_score;
  logic [1:0]  game_state;
  logic        point, game_over;

  int n_checks = 0;
  int n_errors = 0;

  pong_engine dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .up           (up),
    .down         (down),
    .pause        (pause),
    .start        (start),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .player_y     (player_y),
    .cpu_y        (cpu_y),
    .player_score (player_score),
    .cpu_score    (cpu_score),
    .game_state   (game_state),
    .point        (point),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Each tick is a one-cycle strobe driven and released on falling edges, so
  // on return the registered outputs already reflect it.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- Scenario A: serve, walls, misses, game over ----------
    do_reset();
    check("rst ball_x",   ball_x, 315);
    check("rst ball_y",   ball_y, 235);
    check("rst player_y", player_y, 180);
    check("rst cpu_y",    cpu_y, 180);
    check("rst p_score",  player_score, 0);
    check("rst c_score",  cpu_score, 0);
    check("rst state",    game_state, 0);
    check("rst point",    point, 0);
    check("rst over",     game_over, 0);

    ticks(59);
    check("serve59 state", game_state, 0);
    check("serve59 bx",    ball_x, 315);
    ticks(1);
    check("serve60 state", game_state, 1);
    check("serve60 by",    ball_y, 235);
    ticks(1);
    check("k1 bx", ball_x, 311);
    check("k1 by", ball_y, 239);

    ticks(52);
    check("k53 by", ball_y, 447);
    check("k53 bx", ball_x, 103);
    ticks(1);
    check("bottom clamp by", ball_y, 450);
    ticks(1);
    check("bottom bounce by", ball_y, 446);

    ticks(9);
    check("miss k64 bx", ball_x, 59);
    check("miss k64 by", ball_y, 410);
    check("miss k64 cpu_y", cpu_y, 180);
    ticks(9);
    check("k73 bx", ball_x, 23);
    check("k73 c_score", cpu_score, 0);
    ticks(1);
    check("score c_score", cpu_score, 1);
    check("score point", point, 1);
    check("score state", game_state, 2);
    @(negedge clk);
    check("point pulse width", point, 0);
    check("point held state", game_state, 2);
    ticks(1);
    check("point->serve state", game_state, 0);
    check("point->serve bx", ball_x, 315);
    check("point->serve by", ball_y, 235);

    ticks(60);
    check("r2 play state", game_state, 1);
    ticks(53);
    check("r2 k53 by", ball_y, 23);
    ticks(1);
    check("top clamp by", ball_y, 20);
    ticks(1);
    check("top bounce by", ball_y, 24);
    ticks(19);
    check("r2 c_score", cpu_score, 2);
    check("r2 state", game_state, 2);

    ticks(5 * 135);
    check("r7 c_score", cpu_score, 7);
    check("r7 state", game_state, 2);
    ticks(135);
    check("win c_score", cpu_score, 8);
    check("win state", game_state, 3);
    check("win over", game_over, 1);
    check("win p_score", player_score, 0);

    up = 1'b1;
    ticks(5);
    up = 1'b0;
    check("over player_y", player_y, 180);
    check("over state", game_state, 3);
    check("over c_score", cpu_score, 8);

    pause = 1'b1;
    pulse_start();
    pause = 1'b0;
    check("start state", game_state, 0);
    check("start c_score", cpu_score, 0);
    check("start over", game_over, 0);
    check("start bx", ball_x, 315);
    check("start player_y", player_y, 180);

    ticks(30);
    pulse_start();
    ticks(29);
    check("start ignored st", game_state, 0);
    ticks(1);
    check("serve after start", game_state, 1);

    pause = 1'b1;
    ticks(5);
    check("pause play bx", ball_x, 315);
    check("pause play st", game_state, 1);
    pause = 1'b0;
    ticks(1);
    check("unpause bx", ball_x, 311);
    check("unpause by", ball_y, 239);

    // ---------------- Scenario B: paddles, hit, CPU tracking, async reset --
    do_reset();
    up = 1'b1;
    ticks(1);
    check("up1 player_y", player_y, 172);
    ticks(19);
    check("up20 player_y", player_y, 20);
    ticks(5);
    check("up25 clamp", player_y, 20);
    down = 1'b1;
    ticks(5);
    check("up+down hold", player_y, 20);
    down = 1'b0;

    pause = 1'b1;
    ticks(10);
    check("pause paddle", player_y, 20);
    check("pause serve st", game_state, 0);
    pause = 1'b0;
    up = 1'b0;

    down = 1'b1;
    ticks(20);
    check("down20 player_y", player_y, 180);
    check("serve held st", game_state, 0);
    ticks(20);
    check("down40 player_y", player_y, 340);
    check("k10 bx", ball_x, 275);
    ticks(2);
    check("down clamp", player_y, 340);
    down = 1'b0;

    ticks(51);
    check("k63 bx", ball_x, 63);
    check("k63 by", ball_y, 414);
    ticks(1);
    check("hit bx", ball_x, 60);
    check("hit by", ball_y, 410);
    check("hit cpu_y", cpu_y, 180);
    ticks(1);
    check("after hit bx", ball_x, 64);
    check("after hit by", ball_y, 406);
    check("cpu track", cpu_y, 188);

    #2 rst = 1'b1;
    #1;
    check("async bx", ball_x, 315);
    check("async by", ball_y, 235);
    check("async player_y", player_y, 180);
    check("async cpu_y", cpu_y, 180);
    check("async state", game_state, 0);
    @(negedge clk);
    rst = 1'b0;
    ticks(61);
    check("post rst bx", ball_x, 311);
    check("post rst by", ball_y, 239);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pong_engine.md
Name: pong_engine

Overview:
- Tick-driven game-state engine for the VGA pong display, generalised over screen geometry, object sizes, speeds and winning score.
- Owns ball, paddle and score state plus a serve/play/point/game-over state machine.
- Exports positions for the pixel renderer and scores for the seven-segment driver.
- Updates once per `tick` strobe, normally one per frame from the VGA controller. No internal clock division.

Parameters:
- H_RES, 640, active width in pixels
- V_RES, 480, active height in pixels
- BORDER, 20, border thickness; playfield inner edge
- BALL_SIZE, 10, ball side length
- PAD_W, 20, paddle width
- PAD_H, 120, paddle height
- PAD_SPEED, 8, paddle pixels per tick
- BALL_SPEED, 4, ball pixels per tick on each axis
- WIN_SCORE, 8, score that ends the game (must be at most 2**SCORE_W-1)
- SCORE_W, 4, score counter width
- SERVE_TICKS, 60, ticks the ball is held at centre before a serve
- DEADBAND, 4, CPU tracking dead zone in pixels

Ports:
- clk, input, 1, system clock
- rst, input, 1, reset, asynchronous, active-high
- tick, input, 1, one-cycle update strobe
- up, input, 1, player paddle up (level)
- down, input, 1, player paddle down (level)
- pause, input, 1, freezes ball and paddles while high
- start, input, 1, one-cycle pulse; restarts the game from OVER
- ball_x, output, 11, ball top-left x
- ball_y, output, 11, ball top-left y
- player_y, output, 11, left paddle top y
- cpu_y, output, 11, right paddle top y
- player_score, output, SCORE_W, left score
- cpu_score, output, SCORE_W, right score
- game_state, output, 2, 0=SERVE 1=PLAY 2=POINT 3=OVER
- point, output, 1, one-cycle pulse on a scored point
- game_over, output, 1, high in OVER

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - ball at centre: BX0=(H_RES-BALL_SIZE)/2=315, BY0=(V_RES-BALL_SIZE)/2=235
  - both paddles at PY0=(V_RES-PAD_H)/2=180
  - scores 0, state SERVE, serve counter=SERVE_TICKS
  - velocity vx=-BALL_SPEED, vy=+BALL_SPEED
  - point=0
- Update timing: state changes only on cycles with tick=1. All outputs are registered, so new values appear the cycle after tick.
- Arithmetic: all position maths is signed 12-bit internally. Outputs are clamped to never leave the playfield.
- Paddle clamp range: [PMIN,PMAX]=[BORDER, V_RES-BORDER-PAD_H]=[20,340].
- Paddle x positions: player PXL=2*BORDER=40, CPU PXR=H_RES-2*BORDER-PAD_W=580.
- Player paddle (SERVE and PLAY, not paused):
  - up alone: y-=PAD_SPEED; down alone: y+=PAD_SPEED.
  - Both or neither: no move.
  - The result is clamped to [PMIN,PMAX], not rejected.
- CPU paddle:
  - When vx>0, track the ball. Let err=(ball_y+BALL_SIZE/2)-(cpu_y+PAD_H/2). If err>DEADBAND, move down PAD_SPEED; if err<-DEADBAND, move up. Clamp to [PMIN,PMAX].
  - When vx<0, move toward PY0 by at most PAD_SPEED, without overshooting.
- SERVE:
  - Ball held at BX0/BY0.
  - The counter decrements per tick. At 0, go to PLAY.
- PLAY, each tick not paused: compute nx=ball_x+vx, ny=ball_y+vy.
  - Wall, top: if ny<BORDER, then ny=BORDER and vy=+BALL_SPEED.
  - Wall, bottom: if ny>V_RES-BORDER-BALL_SIZE, then clamp ny there and vy=-BALL_SPEED.
  - Player hit: vx<0, ball_x>=PXL+PAD_W, nx<PXL+PAD_W, and ny+BALL_SIZE>player_y and ny<player_y+PAD_H. Then nx=PXL+PAD_W and vx=+BALL_SPEED.
  - CPU hit: the mirror condition against PXR. Then nx=PXR-BALL_SIZE and vx=-BALL_SPEED.
  - CPU scores: nx<BORDER.
  - Player scores: nx+BALL_SIZE>H_RES-BORDER.
  - Priority: paddle hit over score; the wall term applies in the same tick as a hit.
- On a score:
  - Increment the scorer's count and pulse point for one cycle.
  - Next vx points toward the player who conceded; vy is kept.
  - If the new score equals WIN_SCORE, go to OVER; otherwise go to POINT.
- POINT: ball at centre, counter loaded with SERVE_TICKS, then SERVE on the next tick.
- OVER:
  - All motion stops and game_over=1.
  - start clears both scores, resets paddles and ball, loads the counter, and goes to SERVE.
  - start is acted on without waiting for tick.
  - start in any other state is ignored.
- pause: masks tick in SERVE and PLAY (no movement, counter holds). pause does not mask start.
- Reset mid-game: immediately returns to the reset values regardless of state.

Optional Feature:
- TWO_PLAYER_EN: when defined, adds input ports up2 and down2 (1 bit each).
  - cpu_y is driven by up2/down2 with the same rules as the player paddle.
  - The tracking logic and DEADBAND are unused.
- When undefined: ports are absent and the CPU tracking rules apply.

Test Plan:
- Reset then 60 ticks: ball stays at 315/235 and game_state=0. On tick 60, game_state=1. The next tick gives ball_x=311, ball_y=239.
- From player_y=180, hold up for 25 ticks: player_y reaches 20 after 20 ticks and stays 20. Hold up+down: no change.
- Ball at y=22 with vy=-4: next ball_y=20 and vy=+4. Ball at bottom limit 450 with vy=+4: stays 450 and vy=-4.
- Player paddle at 180, ball_x=61, ball_y=200, vx=-4: ball_x becomes 60 and vx=+4. Same with player_y=340: no hit; ball continues, cpu_score increments, point pulses once, state goes to POINT.
- Force cpu_score to 7 and let the ball pass left: cpu_score=8, game_state=3, game_over=1. Ticks and up/down are ignored. A start pulse gives scores 0 and game_state=0.
- Assert rst asynchronously mid-PLAY, between clock edges: all outputs return to reset values without a clock edge.
